bus_select_pipe: RTL and testbench
==================================

// Module: bus_select_pipe
// PURPOSE
//   Parametrised, registered bus source selector for the datapath bus.
//   - Takes NSRC one-hot drive requests (the *out strobes) and picks one source.
//   - Registers the winning word onto the bus, with a 1-cycle latency.
//   - Flags requests that drive more than one source at once.
//   - Can optionally insert a turnaround cycle when the bus owner changes.
//   Sits between the register file / special registers and the shared bus, feeding every *in-enabled register.
// PARAMETERS
//   WIDTH       32  bus word width in bits
//   NSRC        24  number of bus sources (at least 2)
//   HOLD_LAST   1   1: bus_out keeps the last driven word when idle; 0: bus_out = 0 when idle
//   TURNAROUND  0   1: insert one dead cycle when the owner changes; 0: switch back-to-back
//   SEL_W       localparam = $clog2(NSRC)
// PORTS
//   clock         in   1            system clock, rising edge
//   clear         in   1            asynchronous active-high reset
//   src_data      in   NSRC*WIDTH   source words; source i occupies [i*WIDTH +: WIDTH]
//   src_out       in   NSRC         drive requests, expected one-hot or zero
//   conflict_clr  in   1            clears the sticky conflict flag
//   bus_out       out  WIDTH        registered bus word
//   bus_valid     out  1            bus_out carries a driven word this cycle
//   bus_src       out  SEL_W        index of the source currently driving
//   conflict      out  1            sticky flag: a multi-hot request was seen
// BEHAVIOUR
//   Reset
//   - clear is asynchronous and active-high. One clock: clock.
//   - While clear is high: bus_out=0, bus_valid=0, bus_src=0, conflict=0, state=IDLE, counter=0.
//   - Asserting clear mid-transfer aborts the transfer immediately.
//   Source selection (combinational, every cycle)
//   - winner = lowest index i with src_out[i]=1.
//   - req = |src_out.
//   - multi = more than one bit of src_out is set.
//   Latency and output updates
//   - Requests sampled at edge n appear on bus_out / bus_valid / bus_src after edge n (1 cycle).
//   - While DRIVE holds the same owner, bus_out tracks src_data[winner] every cycle.
//   FSM states: IDLE, DRIVE, TURN
//   - IDLE:  req -> DRIVE and load winner. !req -> stay in IDLE, bus_valid=0.
//   - DRIVE: req, same winner -> stay, reload data.
//   - DRIVE: req, different winner -> TURN if TURNAROUND=1, otherwise stay in DRIVE and load the new winner.
//   - DRIVE: !req -> IDLE.
//   - TURN:  lasts exactly one cycle with bus_valid=0, bus_src holding the old owner.
//            Then req -> DRIVE and load the winner sampled at that edge; !req -> IDLE.
//   Idle output
//   - Whenever bus_valid=0: bus_out = last driven word if HOLD_LAST=1, else 0.
//   - A HOLD_LAST=1 bus_out after reset is 0.
//   Conflict handling
//   - Any edge where multi=1 sets conflict.
//   - conflict_clr clears it. If multi and conflict_clr occur together, set wins.
//   - A multi-hot request still drives the lowest-index source; no other state effect.
//   Width rules
//   - src_out bits at index >= NSRC do not exist.
//   - bus_src is zero-extended to SEL_W.
// CONFIGURATION
//   BUS_CONFLICT_CNT_EN
//   - Defined: adds output conflict_cnt (8 bits).
//     - Increments on each cycle with multi=1.
//     - Saturates at 255.
//     - Cleared by clear and by conflict_clr; clr takes priority over increment.
//   - Undefined: no port, no counter logic.
//   - conflict behaves identically either way.
// TESTING
//   - Reset: assert clear mid-DRIVE -> bus_out=0, bus_valid=0, bus_src=0, conflict=0 in the same cycle, without waiting for a clock edge.
//   - Single drive: src_out bit 21 set, src_data[21]=32'hDEADBEEF -> next cycle bus_out=DEADBEEF, bus_valid=1, bus_src=21.
//   - Owner switch, TURNAROUND=1: bit 3 then bit 7 on consecutive cycles -> bus_src=3 valid, then one cycle valid=0, then bus_src=7 valid.
//   - Idle hold: HOLD_LAST=1 and drive 32'h5 then release -> bus_out stays 5 with valid=0. HOLD_LAST=0 -> bus_out=0.
//   - Conflict: src_out=bits 2 and 9 -> bus_src=2, conflict=1 stays set. Pulse conflict_clr -> 0.
//     With BUS_CONFLICT_CNT_EN: 300 multi cycles -> conflict_cnt=255.
//   - Simultaneous: multi and conflict_clr on the same edge -> conflict=1.

Source files
------------

// File: rtl/bus_select_pipe_if.sv
// bus_select_pipe_if: groups the source-side and bus-side signals of bus_select_pipe.
//   master : drives src_data / src_out / conflict_clr, observes the bus outputs.
//   slave  : the selector itself.
// Signals:
//   src_data     NSRC*WIDTH  source words, source i at [i*WIDTH +: WIDTH]
//   src_out      NSRC        drive requests (expected one-hot or zero)
//   conflict_clr 1           clears the sticky conflict flag
//   bus_out      WIDTH       registered bus word
//   bus_valid    1           bus_out carries a driven word
//   bus_src      SEL_W       index of the driving source
//   conflict     1           sticky multi-hot flag
//   conflict_cnt 8           multi-hot cycle counter (only with BUS_CONFLICT_CNT_EN)
interface bus_select_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 24
);
  localparam int unsigned SEL_W = $clog2(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SEL_W-1:0]      bus_src;
  logic                  conflict;
`ifdef BUS_CONFLICT_CNT_EN
  logic [7:0]            conflict_cnt;
`endif

  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_valid, bus_src,
`ifdef BUS_CONFLICT_CNT_EN
    input  conflict_cnt,
`endif
    input  conflict
  );

  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_valid, bus_src,
`ifdef BUS_CONFLICT_CNT_EN
    output conflict_cnt,
`endif
    output conflict
  );
endinterface

// File: rtl/bus_select_pipe.sv
// bus_select_pipe: registered priority selector driving the shared datapath bus.
//   Picks the lowest-index requesting source, registers its word onto the bus
//   (1-cycle latency), flags multi-hot requests in a sticky conflict bit and
//   optionally inserts a dead cycle when the bus owner changes.
// Ports:
//   clock  in  system clock, rising edge
//   clear  in  asynchronous active-high reset
//   bus    bus_select_pipe_if.slave (requests in, bus word / status out)
// Parameters: WIDTH, NSRC (>=2), HOLD_LAST (keep last word when idle),
//   TURNAROUND (dead cycle on owner change).
// Optional feature macro: BUS_CONFLICT_CNT_EN adds the 8-bit saturating
//   conflict_cnt output.
module bus_select_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NSRC       = 24,
  parameter int unsigned HOLD_LAST  = 1,
  parameter int unsigned TURNAROUND = 0
) (
  input logic              clock,
  input logic              clear,
  bus_select_pipe_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] winner;
  logic [WIDTH-1:0] win_word;
  logic             req;
  logic             multi;
  logic             load;

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    winner   = '0;
    win_word = bus.src_data[WIDTH-1:0];
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (bus.src_out[i-1]) begin
        winner   = SEL_W'(i - 1);
        win_word = bus.src_data[(i-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign req   = |bus.src_out;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(bus.src_out & (bus.src_out - NSRC'(1)));

  // A request loads the bus unless it is an owner change in DRIVE with turnaround on.
  always_comb begin
    load       = 1'b0;
    state_next = IDLE;
    case (state)
      IDLE, TURN: begin
        load       = req;
        state_next = req ? DRIVE : IDLE;
      end
      DRIVE: begin
        if (!req) begin
          state_next = IDLE;
        end else if ((TURNAROUND != 0) && (winner != bus.bus_src)) begin
          state_next = TURN;
        end else begin
          load       = 1'b1;
          state_next = DRIVE;
        end
      end
      default: begin
        load       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // bus_src is only rewritten on a load, so TURN keeps showing the old owner.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.bus_out   <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_src   <= '0;
    end else if (load) begin
      bus.bus_out   <= win_word;
      bus.bus_valid <= 1'b1;
      bus.bus_src   <= winner;
    end else begin
      bus.bus_valid <= 1'b0;
      if (HOLD_LAST == 0) begin
        bus.bus_out <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.conflict <= 1'b0;
    end else if (multi) begin
      bus.conflict <= 1'b1;
    end else if (bus.conflict_clr) begin
      bus.conflict <= 1'b0;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.conflict_cnt <= '0;
    end else if (bus.conflict_clr) begin
      bus.conflict_cnt <= '0;
    end else if (multi && (bus.conflict_cnt != 8'hFF)) begin
      bus.conflict_cnt <= bus.conflict_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bus_select_pipe.sv
// tb_bus_select_pipe: directed self-checking bench for bus_select_pipe.
//   dut0: HOLD_LAST=1, TURNAROUND=0   dut1: HOLD_LAST=0, TURNAROUND=1
//   Both see identical stimulus.
module tb_bus_select_pipe;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 24;

  logic clock;
  logic clear;
  int   vectors;
  int   miscompares;

  bus_select_pipe_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bif0 ();
  bus_select_pipe_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bif1 ();

  bus_select_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_LAST(1), .TURNAROUND(0)) dut0 (
    .clock(clock), .clear(clear), .bus(bif0.slave)
  );
  bus_select_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_LAST(0), .TURNAROUND(1)) dut1 (
    .clock(clock), .clear(clear), .bus(bif1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared stimulus fans out to both interfaces.
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  conflict_clr;
  assign bif0.src_data = src_data;
  assign bif1.src_data = src_data;
  assign bif0.src_out = src_out;
  assign bif1.src_out = src_out;
  assign bif0.conflict_clr = conflict_clr;
  assign bif1.conflict_clr = conflict_clr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word(input int unsigned idx, input logic [WIDTH-1:0] w);
    src_data[idx*WIDTH +: WIDTH] = w;
  endtask

  task automatic req_one(input int unsigned idx);
    src_out = '0;
    src_out[idx] = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    src_out = '0;
    conflict_clr = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) set_word(i, 32'hA000_0000 | i);
    tick();
    vectors++;
    if ({bif0.bus_out, bif0.bus_valid, bif0.bus_src, bif0.conflict} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut0: got out=%h v=%b src=%0d c=%b required all zero",
               bif0.bus_out, bif0.bus_valid, bif0.bus_src, bif0.conflict);
    end
    clear = 1'b0;
    // Go mid-DRIVE with a conflict set, then assert clear between edges.
    src_out = '0;
    src_out[1] = 1'b1;
    src_out[6] = 1'b1;
    tick();
    req_one(21);
    tick();
    vectors++;
    if (bif0.bus_valid !== 1'b1 || bif0.bus_src !== 5'd21 || bif0.conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_predrive: got v=%b src=%0d c=%b required v=1 src=21 c=1",
               bif0.bus_valid, bif0.bus_src, bif0.conflict);
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if ({bif0.bus_out, bif0.bus_valid, bif0.bus_src, bif0.conflict} !== '0 ||
        {bif1.bus_out, bif1.bus_valid, bif1.bus_src, bif1.conflict} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got dut0 out=%h v=%b src=%0d c=%b dut1 v=%b required all zero",
               bif0.bus_out, bif0.bus_valid, bif0.bus_src, bif0.conflict, bif1.bus_valid);
    end
    src_out = '0;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_single_drive();
    set_word(21, 32'hDEADBEEF);
    req_one(21);
    tick();
    vectors++;
    if (bif0.bus_out !== 32'hDEADBEEF || bif0.bus_valid !== 1'b1 || bif0.bus_src !== 5'd21) begin
      miscompares++;
      $display("FAIL single_drive: got out=%h v=%b src=%0d required DEADBEEF 1 21",
               bif0.bus_out, bif0.bus_valid, bif0.bus_src);
    end
    // Same owner keeps tracking the source word.
    set_word(21, 32'h1234_5678);
    tick();
    vectors++;
    if (bif0.bus_out !== 32'h1234_5678 || bif1.bus_out !== 32'h1234_5678 || bif1.bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL track_data: got dut0=%h dut1=%h v1=%b required 12345678 12345678 1",
               bif0.bus_out, bif1.bus_out, bif1.bus_valid);
    end
    src_out = '0;
    tick();
  endtask

  task automatic test_idle_hold();
    set_word(4, 32'h5);
    req_one(4);
    tick();
    vectors++;
    if (bif0.bus_out !== 32'h5 || bif1.bus_out !== 32'h5 || bif1.bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_drive: got dut0=%h dut1=%h v1=%b required 5 5 1",
               bif0.bus_out, bif1.bus_out, bif1.bus_valid);
    end
    src_out = '0;
    tick();
    vectors++;
    if (bif0.bus_out !== 32'h5 || bif0.bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_last1: got out=%h v=%b required 5 0", bif0.bus_out, bif0.bus_valid);
    end
    vectors++;
    if (bif1.bus_out !== 32'h0 || bif1.bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_last0: got out=%h v=%b required 0 0", bif1.bus_out, bif1.bus_valid);
    end
  endtask

  task automatic test_owner_switch();
    req_one(3);
    tick();
    vectors++;
    if (bif1.bus_valid !== 1'b1 || bif1.bus_src !== 5'd3 || bif1.bus_out !== 32'hA000_0003) begin
      miscompares++;
      $display("FAIL switch_first: got v=%b src=%0d out=%h required 1 3 A0000003",
               bif1.bus_valid, bif1.bus_src, bif1.bus_out);
    end
    req_one(7);
    tick();
    vectors++;
    if (bif1.bus_valid !== 1'b0 || bif1.bus_src !== 5'd3 || bif1.bus_out !== 32'h0) begin
      miscompares++;
      $display("FAIL switch_turn: got v=%b src=%0d out=%h required 0 3 0",
               bif1.bus_valid, bif1.bus_src, bif1.bus_out);
    end
    vectors++;
    if (bif0.bus_valid !== 1'b1 || bif0.bus_src !== 5'd7 || bif0.bus_out !== 32'hA000_0007) begin
      miscompares++;
      $display("FAIL switch_b2b: got v=%b src=%0d out=%h required 1 7 A0000007",
               bif0.bus_valid, bif0.bus_src, bif0.bus_out);
    end
    tick();
    vectors++;
    if (bif1.bus_valid !== 1'b1 || bif1.bus_src !== 5'd7 || bif1.bus_out !== 32'hA000_0007) begin
      miscompares++;
      $display("FAIL switch_second: got v=%b src=%0d out=%h required 1 7 A0000007",
               bif1.bus_valid, bif1.bus_src, bif1.bus_out);
    end
    // Owner change then release during TURN: must fall back to idle.
    req_one(0);
    tick();
    src_out = '0;
    tick();
    vectors++;
    if (bif1.bus_valid !== 1'b0 || bif0.bus_valid !== 1'b0 || bif0.bus_out !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL turn_release: got v1=%b v0=%b out0=%h required 0 0 A0000000",
               bif1.bus_valid, bif0.bus_valid, bif0.bus_out);
    end
    tick();
    vectors++;
    if (bif1.bus_valid !== 1'b0 || bif1.bus_src !== 5'd7) begin
      miscompares++;
      $display("FAIL turn_idle: got v=%b src=%0d required 0 7", bif1.bus_valid, bif1.bus_src);
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned k = 10; k < 13; k++) begin
      req_one(k);
      tick();
      vectors++;
      if (bif0.bus_valid !== 1'b1 || bif0.bus_src !== 5'(k) || bif0.bus_out !== (32'hA000_0000 | k)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got v=%b src=%0d out=%h required 1 %0d %h",
                 k, bif0.bus_valid, bif0.bus_src, bif0.bus_out, k, 32'hA000_0000 | k);
      end
    end
    src_out = '0;
    tick();
  endtask

  task automatic test_conflict();
    src_out = '0;
    src_out[2] = 1'b1;
    src_out[9] = 1'b1;
    tick();
    vectors++;
    if (bif0.bus_src !== 5'd2 || bif0.bus_valid !== 1'b1 || bif0.conflict !== 1'b1 ||
        bif0.bus_out !== 32'hA000_0002) begin
      miscompares++;
      $display("FAIL conflict_set: got src=%0d v=%b c=%b out=%h required 2 1 1 A0000002",
               bif0.bus_src, bif0.bus_valid, bif0.conflict, bif0.bus_out);
    end
    src_out = '0;
    tick();
    tick();
    vectors++;
    if (bif0.conflict !== 1'b1 || bif1.conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_sticky: got c0=%b c1=%b required 1 1", bif0.conflict, bif1.conflict);
    end
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    vectors++;
    if (bif0.conflict !== 1'b0 || bif1.conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_clr: got c0=%b c1=%b required 0 0", bif0.conflict, bif1.conflict);
    end
  endtask

  task automatic test_simultaneous();
    src_out = '0;
    src_out[5] = 1'b1;
    src_out[23] = 1'b1;
    conflict_clr = 1'b1;
    tick();
    vectors++;
    if (bif0.conflict !== 1'b1 || bif0.bus_src !== 5'd5) begin
      miscompares++;
      $display("FAIL simul_set_wins: got c=%b src=%0d required 1 5", bif0.conflict, bif0.bus_src);
    end
    src_out = '0;
    tick();
    conflict_clr = 1'b0;
    vectors++;
    if (bif0.conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_then_clr: got c=%b required 0", bif0.conflict);
    end
  endtask

`ifdef BUS_CONFLICT_CNT_EN
  task automatic test_conflict_cnt();
    src_out = '0;
    src_out[0] = 1'b1;
    src_out[1] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    vectors++;
    if (bif0.conflict_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL cnt_three: got %0d required 3", bif0.conflict_cnt);
    end
    for (int k = 3; k < 300; k++) tick();
    vectors++;
    if (bif0.conflict_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL cnt_saturate: got %0d required 255", bif0.conflict_cnt);
    end
    conflict_clr = 1'b1;
    tick();
    vectors++;
    if (bif0.conflict_cnt !== 8'd0 || bif0.conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL cnt_clr_priority: got cnt=%0d c=%b required 0 1", bif0.conflict_cnt, bif0.conflict);
    end
    src_out = '0;
    tick();
    conflict_clr = 1'b0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    src_data = '0;
    test_reset();
    test_single_drive();
    test_idle_hold();
    test_owner_switch();
    test_back_to_back();
    test_conflict();
    test_simultaneous();
`ifdef BUS_CONFLICT_CNT_EN
    test_conflict_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
